// File: rtl/cam_pack_pkg.sv
// Shared definitions for the camera pack selector: pack field layout, pack width and OSD colours.
package cam_pack_pkg;

    typedef enum logic [3:0] {
        FLD_PCLK,
        FLD_HSYNC,
        FLD_VSYNC,
        FLD_DE,
        FLD_R,
        FLD_G,
        FLD_B,
        FLD_X,
        FLD_Y
    } pack_field_t;

    localparam int N_CAM_MAX = 8;

    localparam logic [23:0] CAM_OSD_COLORS [N_CAM_MAX] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
        24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'h808080
    };

    function automatic int pack_size(input int h_act, input int v_act);
        return 28 + $clog2(h_act) + $clog2(v_act);
    endfunction

    // LSB position of a field; layout MSB first is {pclk,hsync,vsync,de,r,g,b,x,y}.
    function automatic int field_lsb(input pack_field_t fld, input int xw, input int yw);
        int lsb;
        lsb = 0;
        case (fld)
            FLD_Y:     lsb = 0;
            FLD_X:     lsb = yw;
            FLD_B:     lsb = xw + yw;
            FLD_G:     lsb = xw + yw + 8;
            FLD_R:     lsb = xw + yw + 16;
            FLD_DE:    lsb = xw + yw + 24;
            FLD_VSYNC: lsb = xw + yw + 25;
            FLD_HSYNC: lsb = xw + yw + 26;
            default:   lsb = xw + yw + 27;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Button debouncer: 2-flop synchroniser, hold counter, one-cycle press pulse on a debounced 0->1.
// Generic enough to be shared with the trigger generator.
module key_debounce #(
    parameter int HOLD = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic             key_meta_reg;
    logic             key_sync_reg;
    logic             stable_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_reg <= 1'b0;
            key_sync_reg <= 1'b0;
            stable_reg   <= 1'b0;
            press_reg    <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            key_meta_reg <= key;
            key_sync_reg <= key_meta_reg;
            press_reg    <= 1'b0;
            if (key_sync_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(HOLD - 1)) begin
                stable_reg <= key_sync_reg;
                press_reg  <= key_sync_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cam_pack_selector.sv
// N-channel video pack selector; channel changes only on the target's vsync edge (or a timeout).
// Optional corner OSD tag enabled by defining CAM_SEL_OSD_EN.
module cam_pack_selector
    import cam_pack_pkg::*;
#(
    parameter int N_CAM    = 4,
    parameter int H_ACT    = 1280,
    parameter int V_ACT    = 720,
    parameter int KEY_HOLD = 500_000,
    parameter int TIMEOUT  = 2**24,
    parameter int DELAY    = 2,
    localparam int PACK_SIZE = pack_size(H_ACT, V_ACT),
    localparam int SEL_W     = (N_CAM > 1) ? $clog2(N_CAM) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CAM*PACK_SIZE-1:0] i_packs,
    input  logic                       key,
    input  logic                       sel_valid,
    input  logic [SEL_W-1:0]           sel_id,
    output logic [PACK_SIZE-1:0]       o_pack,
    output logic [SEL_W-1:0]           cur_sel,
    output logic                       pending,
    output logic                       timeout
);

    localparam int XW     = $clog2(H_ACT);
    localparam int YW     = $clog2(V_ACT);
    localparam int VS_OFF = field_lsb(FLD_VSYNC, XW, YW);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SWITCH} state_t;

    if (N_CAM < 2 || N_CAM > N_CAM_MAX) begin : g_bad_n_cam
        $error("cam_pack_selector: N_CAM must be in 2..8");
    end
    if (DELAY < 1) begin : g_bad_delay
        $error("cam_pack_selector: DELAY must be >= 1");
    end

    // Per-channel vsync synchroniser and rising-edge detect.
    logic [N_CAM-1:0] vs_raw;
    logic [N_CAM-1:0] vs_meta_reg;
    logic [N_CAM-1:0] vs_sync_reg;
    logic [N_CAM-1:0] vs_prev_reg;
    logic [N_CAM-1:0] vs_rise;

    for (genvar gi = 0; gi < N_CAM; gi++) begin : g_vs
        assign vs_raw[gi] = i_packs[gi*PACK_SIZE + VS_OFF];
    end
    assign vs_rise = vs_sync_reg & ~vs_prev_reg;

    logic press;

    key_debounce #(.HOLD(KEY_HOLD)) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .press (press)
    );

    state_t            state_reg;
    logic [SEL_W-1:0]  target_reg;
    logic [SEL_W-1:0]  cur_sel_reg;
    logic [WAIT_W-1:0] wait_reg;
    logic              timeout_reg;

    // Direct select outranks the key; out-of-range ids behave as if no strobe came.
    logic             sel_ok;
    logic             req_valid;
    logic [SEL_W-1:0] next_sel;
    logic [SEL_W-1:0] req_target;

    assign sel_ok     = sel_valid && (int'(sel_id) < N_CAM);
    assign next_sel   = (cur_sel_reg == SEL_W'(N_CAM - 1)) ? '0 : cur_sel_reg + SEL_W'(1);
    assign req_valid  = sel_ok || press;
    assign req_target = sel_ok ? sel_id : next_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_meta_reg <= '0;
            vs_sync_reg <= '0;
            vs_prev_reg <= '0;
            state_reg   <= ST_IDLE;
            target_reg  <= '0;
            cur_sel_reg <= '0;
            wait_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            vs_meta_reg <= vs_raw;
            vs_sync_reg <= vs_meta_reg;
            vs_prev_reg <= vs_sync_reg;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_target != cur_sel_reg) begin
                        state_reg  <= ST_ARM;
                        target_reg <= req_target;
                        wait_reg   <= '0;
                    end
                end
                ST_ARM: begin
                    if (req_valid) begin
                        target_reg <= req_target;
                        wait_reg   <= '0;
                    end else if (vs_rise[target_reg]) begin
                        state_reg <= ST_SWITCH;
                    end else if (wait_reg == WAIT_W'(TIMEOUT - 1)) begin
                        state_reg   <= ST_SWITCH;
                        timeout_reg <= 1'b1;
                    end else begin
                        wait_reg <= wait_reg + WAIT_W'(1);
                    end
                end
                ST_SWITCH: begin
                    cur_sel_reg <= target_reg;
                    state_reg   <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Output pipeline; the last stage optionally carries the OSD overwrite.
    logic [PACK_SIZE-1:0] mux_pack;
    logic [PACK_SIZE-1:0] pipe_reg  [DELAY];
    logic [PACK_SIZE-1:0] pipe_next [DELAY];
    logic [PACK_SIZE-1:0] last_next;

    assign mux_pack = i_packs[cur_sel_reg*PACK_SIZE +: PACK_SIZE];

    for (genvar gi = 0; gi < DELAY; gi++) begin : g_pipe
        if (gi == 0) begin : g_first
            assign pipe_next[gi] = mux_pack;
        end else begin : g_chain
            assign pipe_next[gi] = pipe_reg[gi-1];
        end
    end

`ifdef CAM_SEL_OSD_EN
    localparam int DE_OFF = field_lsb(FLD_DE, XW, YW);
    localparam int B_OFF  = field_lsb(FLD_B, XW, YW);
    localparam int X_OFF  = field_lsb(FLD_X, XW, YW);
    localparam int Y_OFF  = field_lsb(FLD_Y, XW, YW);

    logic [PACK_SIZE-1:0] osd_in;
    assign osd_in = pipe_next[DELAY-1];

    always_comb begin
        last_next = osd_in;
        if (osd_in[DE_OFF] && (osd_in[X_OFF +: XW] < XW'(16)) && (osd_in[Y_OFF +: YW] < YW'(16))) begin
            last_next[B_OFF +: 24] = CAM_OSD_COLORS[3'(cur_sel_reg)];
        end
    end
`else
    assign last_next = pipe_next[DELAY-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DELAY - 1; i++) begin
                pipe_reg[i] <= pipe_next[i];
            end
            pipe_reg[DELAY-1] <= last_next;
        end
    end

    assign o_pack  = pipe_reg[DELAY-1];
    assign cur_sel = cur_sel_reg;
    assign pending = (state_reg == ST_ARM);
    assign timeout = timeout_reg;

endmodule
